// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared serial-arithmetic types (FSM state encodings).
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module   : full_adder
// Purpose  : One-bit full adder from two half adders and an OR for the carry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s0),
        .o_carry (w_c0)
    );

    half_adder u_ha1 (
        .i_a     (w_s0),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (w_c1)
    );

    assign o_cout = w_c0 | w_c1;

endmodule : full_adder

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// Module   : half_adder
// Purpose  : One-bit half adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule : half_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder, one bit per cycle, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                   C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0]   C_LAST  = C_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_carry;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 w_sum_bit;
    logic                 w_carry;

    full_adder u_fa (
        .i_a    (r_op_a[0]),
        .i_b    (r_op_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum_bit),
        .o_cout (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: the sum register doubles as the result, filled from the MSB end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= b;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
                    r_carry <= w_carry;
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    // Hold at the last index so the counter never wraps.
                    if (r_cnt != C_LAST) begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic        clk;
    logic        rst;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        cout8;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    int total = 0;
    int bad   = 0;
    int acc8  = 0;
    int acc16 = 0;
    int dn8   = 0;
    int dn16  = 0;

    logic [16:0] q8[$];
    logic [16:0] q16[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: every done pulse pops one expected {cout,sum}.
    always @(negedge clk) begin
        if (!rst && done8) begin
            dn8++;
            if (q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
            else check("sum8", 32'({cout8, sum8}), 32'(q8.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            dn16++;
            if (q16.size() == 0) check("done16_unexpected", 32'd1, 32'd0);
            else check("sum16", 32'({cout16, sum16}), 32'(q16.pop_front()));
        end
    end

    // Caller is positioned at a negedge with the DUT idle; returns at the done negedge.
    task automatic run8(input logic [7:0] x, input logic [7:0] y);
        bit seen;
        start8 = 1'b1;
        a8     = x;
        b8     = y;
        q8.push_back(17'(x) + 17'(y));
        acc8++;
        @(negedge clk);
        start8 = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done8) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("done8_timeout", 32'd0, 32'd1);
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y);
        bit seen;
        start16 = 1'b1;
        a16     = x;
        b16     = y;
        q16.push_back(17'(x) + 17'(y));
        acc16++;
        @(negedge clk);
        start16 = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done16) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("done16_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        int t_first;
        int t_second;

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum",  32'(sum8),  32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_sum16", 32'({cout16, sum16, busy16, done16}), 32'd0);

        // 0F+01 with start on the first edge after reset release; busy/done timing
        @(negedge clk);
        rst = 1'b0; start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01;
        q8.push_back(17'h010);
        acc8++;
        busy_cnt = 0;
        done_at  = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) start8 = 1'b0;
            if (busy8) busy_cnt++;
            if (done8 && done_at < 0) done_at = k;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd9);
        check("done_latency", 32'(done_at), 32'd8);
        check("hold_sum", 32'(sum8), 32'h10);
        check("hold_cout", 32'(cout8), 32'd0);

        // Boundary operand pairs
        @(negedge clk); run8(8'hFF, 8'h01);
        @(negedge clk); run8(8'hAA, 8'h55);
        @(negedge clk); run8(8'hFF, 8'hFF);
        @(negedge clk); run8(8'h00, 8'h00);

        // start held high; operands changed during SHIFT must not matter
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
        q8.push_back(17'h04B);
        acc8++;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01;
        q8.push_back(17'h002);
        acc8++;
        t_first  = -1;
        t_second = -1;
        for (int i = 0; i < 40 && t_second < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (done8) begin
                if (t_first < 0) t_first = i;
                else t_second = i;
            end
        end
        start8 = 1'b0;
        check("b2b_spacing", 32'(t_second - t_first), 32'd10);

        // Reset during the 4th SHIFT cycle aborts without a done pulse
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum",  32'(sum8),  32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run8(8'h03, 8'h04);

        // WIDTH=16 boundaries
        @(negedge clk); run16(16'hFFFF, 16'h0001);
        @(negedge clk); run16(16'h1234, 16'h4321);

        // Random regression
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            run8(8'($urandom), 8'($urandom));
        end
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            run16(16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge clk);
        check("done8_count",  32'(dn8),  32'(acc8));
        check("done16_count", 32'(dn16), 32'(acc16));
        check("q8_empty",  32'(q8.size()),  32'd0);
        check("q16_empty", 32'(q16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
